// File: rtl/dmi_access_ctrl.sv
// dmi_access_ctrl: turns DTM scan-register updates into single DMI request/response transactions.
// An update in IDLE latches {addr, data, op} from the shift register. The request is then
// presented until it is accepted. The block then waits for the response, with an optional
// timeout. Sticky error status is reported back to the DTM in the dmistat format.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   dmi_update_i        pulse: scan register updated (starts an access when idle)
//   dmi_capture_i       pulse: scan register captured (busy error if an access is in flight)
//   dmi_shift_i         {addr[40:34], data[33:2], op[1:0]}
//   dmireset_i          pulse: clear sticky error
//   dmihardreset_i      pulse: abort access and clear error
//   dmi_req_o/_valid_o  request {addr, op, data} with valid, dmi_req_ready_i accepts it
//   dmi_resp_i          response {data, resp} with dmi_resp_valid_i, accepted by dmi_resp_ready_o
//   dmi_capture_o       {addr_q, data_q, status}
//   dmistat_o           sticky error (0 ok, 2 failed, 3 busy)
//   busy_o              an access is in flight
module dmi_access_ctrl #(
  parameter int unsigned TimeoutCycles = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        dmi_update_i,
  input  logic        dmi_capture_i,
  input  logic [40:0] dmi_shift_i,
  input  logic        dmireset_i,
  input  logic        dmihardreset_i,
  output logic [40:0] dmi_req_o,
  output logic        dmi_req_valid_o,
  input  logic        dmi_req_ready_i,
  input  logic [33:0] dmi_resp_i,
  input  logic        dmi_resp_valid_i,
  output logic        dmi_resp_ready_o,
  output logic [40:0] dmi_capture_o,
  output logic [1:0]  dmistat_o,
  output logic        busy_o
);

  localparam logic [1:0] DtmRead    = 2'd1;
  localparam logic [1:0] DtmWrite   = 2'd2;
  localparam logic [1:0] DtmSuccess = 2'd0;
  localparam logic [1:0] ErrFailed  = 2'd2;
  localparam logic [1:0] ErrBusy    = 2'd3;

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e      state_q, state_d;
  logic [6:0]  addr_q, addr_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  error_q, error_d;
  logic [31:0] cnt_q, cnt_d;
  logic [1:0]  new_err;

  logic [6:0]  shift_addr;
  logic [31:0] shift_data;
  logic [1:0]  shift_op;

  assign shift_addr = dmi_shift_i[40:34];
  assign shift_data = dmi_shift_i[33:2];
  assign shift_op   = dmi_shift_i[1:0];

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    op_d             = op_q;
    data_d           = data_q;
    cnt_d            = cnt_q;
    new_err          = 2'd0;
    dmi_req_valid_o  = 1'b0;
    dmi_resp_ready_o = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (dmi_update_i && (error_q == 2'd0) &&
            ((shift_op == DtmRead) || (shift_op == DtmWrite))) begin
          addr_d  = shift_addr;
          op_d    = shift_op;
          data_d  = shift_data;
          state_d = StReq;
        end
      end
      StReq: begin
        dmi_req_valid_o = 1'b1;
        if (dmi_req_ready_i) begin
          state_d = StWait;
          cnt_d   = 32'd0;
        end
      end
      StWait: begin
        dmi_resp_ready_o = 1'b1;
        if (dmi_resp_valid_i) begin
          state_d = StIdle;
          if (op_q == DtmRead) begin
            data_d = dmi_resp_i[33:2];
          end
          if (dmi_resp_i[1:0] != DtmSuccess) begin
            new_err = ErrFailed;
          end
        end else if (TimeoutCycles != 0) begin
          cnt_d = cnt_q + 32'd1;
          if (cnt_d == TimeoutCycles) begin
            state_d = StIdle;
            new_err = ErrFailed;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Any scan activity while an access is in flight is a busy error, including the response
    // cycle itself; it takes precedence over a coincident response failure.
    if ((state_q != StIdle) && (dmi_update_i || dmi_capture_i)) begin
      new_err = ErrBusy;
    end

    // dmireset clears first so that an error raised in the same cycle still sticks.
    error_d = error_q;
    if (dmireset_i) begin
      error_d = 2'd0;
    end
    if ((new_err != 2'd0) && (error_d == 2'd0)) begin
      error_d = new_err;
    end

    if (dmihardreset_i) begin
      state_d = StIdle;
      cnt_d   = 32'd0;
      error_d = 2'd0;
      addr_d  = addr_q;
      op_d    = op_q;
      data_d  = data_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      addr_q  <= 7'd0;
      op_q    <= 2'd0;
      data_q  <= 32'd0;
      error_q <= 2'd0;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      data_q  <= data_d;
      error_q <= error_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dmi_req_o     = {addr_q, op_q, data_q};
  assign busy_o        = (state_q != StIdle);
  assign dmistat_o     = error_q;
  assign dmi_capture_o = {addr_q, data_q,
                          ((state_q != StIdle) && (error_q == 2'd0)) ? ErrBusy : error_q};

endmodule

// File: tb/tb_dmi_access_ctrl.sv
// Testbench for dmi_access_ctrl. Two instances share all stimulus: one with the timeout
// disabled and one with TimeoutCycles = 4. Expected requests are queued when an update is
// driven and compared when the handshake is seen.
module tb_dmi_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        dmi_update, dmi_capture, dmireset, dmihardreset;
  logic [40:0] dmi_shift;
  logic        dmi_req_ready, dmi_resp_valid;
  logic [33:0] dmi_resp;

  logic [40:0] req0, req4, cap0, cap4;
  logic        req_valid0, req_valid4, resp_ready0, resp_ready4, busy0, busy4;
  logic [1:0]  stat0, stat4;

  int unsigned n_checks = 0;
  int unsigned n_bad    = 0;
  int unsigned valid_cycles = 0;
  logic [40:0] exp_req_q[$];

  always #5 clk = ~clk;

  dmi_access_ctrl #(.TimeoutCycles(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .dmi_update_i(dmi_update), .dmi_capture_i(dmi_capture),
    .dmi_shift_i(dmi_shift), .dmireset_i(dmireset), .dmihardreset_i(dmihardreset),
    .dmi_req_o(req0), .dmi_req_valid_o(req_valid0), .dmi_req_ready_i(dmi_req_ready),
    .dmi_resp_i(dmi_resp), .dmi_resp_valid_i(dmi_resp_valid), .dmi_resp_ready_o(resp_ready0),
    .dmi_capture_o(cap0), .dmistat_o(stat0), .busy_o(busy0)
  );

  dmi_access_ctrl #(.TimeoutCycles(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .dmi_update_i(dmi_update), .dmi_capture_i(dmi_capture),
    .dmi_shift_i(dmi_shift), .dmireset_i(dmireset), .dmihardreset_i(dmihardreset),
    .dmi_req_o(req4), .dmi_req_valid_o(req_valid4), .dmi_req_ready_i(dmi_req_ready),
    .dmi_resp_i(dmi_resp), .dmi_resp_valid_i(dmi_resp_valid), .dmi_resp_ready_o(resp_ready4),
    .dmi_capture_o(cap4), .dmistat_o(stat4), .busy_o(busy4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [40:0] cap(input logic [6:0] a, input logic [31:0] d,
                                      input logic [1:0] s);
    return {a, d, s};
  endfunction

  // Request scoreboard: every accepted handshake must match the oldest queued request.
  always @(negedge clk) begin
    if (!rst && req_valid0) valid_cycles++;
    if (!rst && req_valid0 && dmi_req_ready) begin
      check("req_sb_nonempty", exp_req_q.size() != 0, 1);
      if (exp_req_q.size() != 0) begin
        logic [40:0] e;
        e = exp_req_q.pop_front();
        check("req_payload", req0, e);
        check("req4_payload", req4, e);
        check("req4_valid", req_valid4, 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_update(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op,
                           input bit accept);
    dmi_shift  = {a, d, op};
    dmi_update = 1'b1;
    if (accept) exp_req_q.push_back({a, op, d});
    tick();
    dmi_update = 1'b0;
  endtask

  task automatic respond(input logic [31:0] d, input logic [1:0] r);
    dmi_resp       = {d, r};
    dmi_resp_valid = 1'b1;
    tick();
    dmi_resp_valid = 1'b0;
  endtask

  task automatic pulse_dmireset();
    dmireset = 1'b1;
    tick();
    dmireset = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    dmi_update = 1'b0; dmi_capture = 1'b0; dmireset = 1'b0; dmihardreset = 1'b0;
    dmi_shift = '0; dmi_req_ready = 1'b0; dmi_resp_valid = 1'b0; dmi_resp = '0;
    tick();
    tick();
    check("rst_busy", busy0, 0);
    check("rst_stat", stat0, 0);
    check("rst_req_valid", req_valid0, 0);
    check("rst_resp_ready", resp_ready0, 0);
    check("rst_capture", cap0, 0);
    rst = 1'b0;
    tick();

    // Read with ready after two cycles, response in the first WAIT cycle.
    do_update(7'h11, 32'h0, 2'd1, 1'b1);
    check("rd_busy_req", busy0, 1);
    check("rd_resp_ready_in_req", resp_ready0, 0);
    tick();
    tick();
    dmi_req_ready = 1'b1;
    tick();
    dmi_req_ready = 1'b0;
    check("rd_resp_ready_wait", resp_ready0, 1);
    check("rd_req_valid_wait", req_valid0, 0);
    respond(32'hDEADBEEF, 2'd0);
    check("rd_capture", cap0, cap(7'h11, 32'hDEADBEEF, 2'd0));
    check("rd_stat", stat0, 0);
    check("rd_busy_done", busy0, 0);

    // Write with ready held high: one valid cycle, data not replaced by the response.
    dmi_req_ready = 1'b1;
    valid_cycles = 0;
    do_update(7'h04, 32'h12345678, 2'd2, 1'b1);
    tick();
    respond(32'hCAFEF00D, 2'd0);
    check("wr_valid_cycles", valid_cycles, 1);
    check("wr_capture", cap0, cap(7'h04, 32'h12345678, 2'd0));

    // NOP update is ignored.
    do_update(7'h33, 32'h1, 2'd0, 1'b0);
    check("nop_busy", busy0, 0);
    check("nop_capture", cap0, cap(7'h04, 32'h12345678, 2'd0));

    // Busy: second update in WAIT, first access completes, later update ignored until dmireset.
    do_update(7'h05, 32'h0, 2'd1, 1'b1);
    tick();
    do_update(7'h06, 32'h0, 2'd1, 1'b0);
    check("busy_stat", stat0, 3);
    check("busy_still_busy", busy0, 1);
    respond(32'h13572468, 2'd0);
    check("busy_capture", cap0, cap(7'h05, 32'h13572468, 2'd3));
    do_update(7'h07, 32'h0, 2'd1, 1'b0);
    check("busy_ignored", busy0, 0);
    check("busy_ignored_cap", cap0, cap(7'h05, 32'h13572468, 2'd3));
    pulse_dmireset();
    check("busy_cleared", stat0, 0);
    do_update(7'h07, 32'h0, 2'd1, 1'b1);
    tick();
    respond(32'h2468ACE0, 2'd0);
    check("busy_recover", cap0, cap(7'h07, 32'h2468ACE0, 2'd0));

    // Update coincident with the response is busy and not taken.
    do_update(7'h12, 32'h0, 2'd1, 1'b1);
    tick();
    dmi_shift  = {7'h13, 32'h0, 2'd1};
    dmi_update = 1'b1;
    respond(32'h0000BEEF, 2'd0);
    dmi_update = 1'b0;
    check("coinc_stat", stat0, 3);
    check("coinc_idle", busy0, 0);
    pulse_dmireset();

    // Failed response.
    do_update(7'h08, 32'h0, 2'd1, 1'b1);
    tick();
    respond(32'h11112222, 2'd2);
    check("fail_capture", cap0, cap(7'h08, 32'h11112222, 2'd2));
    check("fail_stat4", stat4, 2);
    pulse_dmireset();

    // First error wins.
    do_update(7'h09, 32'hA5A5A5A5, 2'd2, 1'b1);
    dmi_capture = 1'b1;
    tick();
    dmi_capture = 1'b0;
    check("sticky_busy", stat0, 3);
    respond(32'h0, 2'd2);
    check("sticky_keep", stat0, 3);
    check("sticky_wr_data", cap0, cap(7'h09, 32'hA5A5A5A5, 2'd3));
    pulse_dmireset();

    // dmireset coincident with a new error records the new error.
    do_update(7'h0E, 32'h0, 2'd1, 1'b1);
    dmi_capture = 1'b1;
    tick();
    dmi_capture = 1'b0;
    dmireset = 1'b1;
    respond(32'h5555AAAA, 2'd2);
    dmireset = 1'b0;
    check("rst_coinc_stat", stat0, 2);
    pulse_dmireset();
    check("rst_coinc_clear", stat0, 0);

    // Timeout only on the TimeoutCycles = 4 instance.
    do_update(7'h0A, 32'h0, 2'd1, 1'b1);
    tick();
    tick();
    tick();
    tick();
    check("to_not_yet", busy4, 1);
    tick();
    check("to_idle", busy4, 0);
    check("to_stat", stat4, 2);
    check("to_cap4", {cap4[40:34], cap4[1:0]}, {7'h0A, 2'd2});
    check("to_disabled_busy", busy0, 1);
    check("to_disabled_stat", stat0, 0);
    respond(32'h0F0F0F0F, 2'd0);
    check("to_dut0_done", cap0, cap(7'h0A, 32'h0F0F0F0F, 2'd0));
    check("to_dut4_ignore", cap4[1:0], 2);
    pulse_dmireset();

    // Hardreset in REQ.
    dmi_req_ready = 1'b0;
    do_update(7'h0B, 32'h0, 2'd1, 1'b1);
    dmi_capture = 1'b1;
    tick();
    dmi_capture = 1'b0;
    check("hr_pre_stat", stat0, 3);
    dmihardreset = 1'b1;
    tick();
    dmihardreset = 1'b0;
    void'(exp_req_q.pop_front());  // aborted, never handshaken
    check("hr_valid", req_valid0, 0);
    check("hr_busy", busy0, 0);
    check("hr_stat", stat0, 0);
    check("hr_addr_kept", cap0[40:34], 7'h0B);
    dmi_req_ready = 1'b1;
    do_update(7'h0C, 32'h0, 2'd1, 1'b1);
    tick();
    respond(32'h77778888, 2'd0);
    check("hr_after_read", cap0, cap(7'h0C, 32'h77778888, 2'd0));

    // Reset mid-access abandons it.
    dmi_req_ready = 1'b0;
    do_update(7'h0D, 32'h0, 2'd1, 1'b1);
    rst = 1'b1;
    #1;
    void'(exp_req_q.pop_front());  // abandoned by reset
    check("mid_rst_valid", req_valid0, 0);
    check("mid_rst_busy", busy0, 0);
    check("mid_rst_capture", cap0, 0);
    tick();
    rst = 1'b0;
    tick();
    check("mid_rst_after", busy0, 0);
    check("sb_drained", exp_req_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
